qspi_macro_sequencer: RTL and testbench

- Top-level macro controller for the UART-driven QSPI flash programmer.
- Drives the shared macro_states/macro_states_valid command bus, which feeds both the UART comm state machine and the QSPI flash controller.
- Runs the user menu loop: print menu, read choice, then sequence UART prompts, number entry, file buffering, flash commands and status polling.
- Only one macro command is outstanding at a time.

---
 rtl/qspi_macro_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_qspi_macro_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_macro_sequencer.sv
// Top-level macro sequencer for the UART-driven QSPI flash programmer.
// Issues one macro command at a time on the shared macro_states bus and walks the user menu.
module qspi_macro_sequencer #(
    parameter int unsigned PAGE_BYTES  = 256,
    parameter int unsigned SR_POLL_MAX = 65535,
    parameter int unsigned WIP_BIT     = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  macro_states,
    output logic        macro_states_valid,
    input  logic        uart_done,
    input  logic [31:0] uart_rx_num,
    output logic [15:0] uart_rx_cnt,
    input  logic        flash_done,
    input  logic [7:0]  flash_sr,
    output logic [31:0] flash_addr,
    output logic        err_timeout,
    output logic        seq_busy
);

    typedef enum logic [3:0] {
        StMenu, StChoice, StRdid, StAddrQ, StAddrRx, StErase, StLenQ,
        StLenRx, StFileQ, StPageBuf, StPageWr, StPoll, StNewline
    } state_t;

    localparam logic [31:0] PageLen = 32'(PAGE_BYTES);
    localparam logic [31:0] PollMax = 32'(SR_POLL_MAX);

    state_t      state_q, state_d;
    logic        waiting_q, waiting_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] poll_q, poll_d;
    logic [3:0]  choice_q, choice_d;
    logic        timeout_q, timeout_d;

    logic [3:0]  cur_code;
    logic        target_done;

    always_comb begin
        case (state_q)
            StMenu:    cur_code = 4'h1;
            StChoice:  cur_code = 4'h5;
            StRdid:    cur_code = 4'hB;
            StAddrQ:   cur_code = 4'h2;
            StAddrRx:  cur_code = 4'h5;
            StErase:   cur_code = 4'hA;
            StLenQ:    cur_code = 4'h3;
            StLenRx:   cur_code = 4'h5;
            StFileQ:   cur_code = 4'h6;
            StPageBuf: cur_code = 4'h7;
            StPageWr:  cur_code = 4'hC;
            StPoll:    cur_code = 4'hE;
            StNewline: cur_code = 4'h4;
            default:   cur_code = 4'h0;
        endcase
    end

    // Codes 1..7 belong to the UART engine, A..F to the flash controller.
    assign target_done = cur_code[3] ? flash_done : uart_done;

    always_comb begin
        state_d   = state_q;
        waiting_d = waiting_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        choice_d  = choice_q;
        timeout_d = 1'b0;

        if (cur_code == 4'h0) begin
            state_d   = StMenu;
            waiting_d = 1'b0;
            busy_d    = 1'b0;
        end else if (!waiting_q) begin
            if (!target_done) begin
                code_d    = cur_code;
                valid_d   = 1'b1;
                busy_d    = 1'b1;
                waiting_d = 1'b1;
                if (state_q == StPageBuf) begin
                    cnt_d = (len_q < PageLen) ? len_q[15:0] : PageLen[15:0];
                end
                if (state_q == StPoll) begin
                    poll_d = poll_q + 32'd1;
                end
            end
        end else if (target_done) begin
            busy_d    = 1'b0;
            waiting_d = 1'b0;
            case (state_q)
                StMenu:   state_d = StChoice;
                StChoice: begin
                    choice_d = uart_rx_num[3:0];
                    case (uart_rx_num[3:0])
                        4'd1:       state_d = StRdid;
                        4'd2, 4'd4: state_d = StAddrQ;
                        default:    state_d = StNewline;
                    endcase
                end
                StRdid:   state_d = StNewline;
                StAddrQ:  state_d = StAddrRx;
                StAddrRx: begin
                    if (choice_q == 4'd2) begin
                        addr_d  = {uart_rx_num[31:12], 12'h000};
                        state_d = StErase;
                    end else begin
                        addr_d  = uart_rx_num;
                        state_d = StLenQ;
                    end
                end
                StErase:  state_d = StPoll;
                StLenQ:   state_d = StLenRx;
                StLenRx: begin
                    len_d   = uart_rx_num;
                    state_d = (uart_rx_num == 32'd0) ? StNewline : StFileQ;
                end
                StFileQ:   state_d = StPageBuf;
                StPageBuf: state_d = StPageWr;
                StPageWr: begin
                    len_d   = (len_q > {16'h0, cnt_q}) ? len_q - {16'h0, cnt_q} : 32'd0;
                    state_d = StPoll;
                end
                StPoll: begin
                    if (flash_sr[WIP_BIT]) begin
                        if (poll_q >= PollMax) begin
                            timeout_d = 1'b1;
                            poll_d    = 32'd0;
                            state_d   = StNewline;
                        end
                    end else begin
                        poll_d = 32'd0;
                        if (choice_q == 4'd2) begin
                            state_d = StNewline;
                        end else begin
                            addr_d  = addr_q + {16'h0, cnt_q};
                            state_d = (len_q != 32'd0) ? StPageBuf : StNewline;
                        end
                    end
                end
                StNewline: state_d = StMenu;
                default:   state_d = StMenu;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StMenu;
            waiting_q <= 1'b0;
            code_q    <= 4'h0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= 32'd0;
            len_q     <= 32'd0;
            cnt_q     <= 16'd0;
            poll_q    <= 32'd0;
            choice_q  <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waiting_q <= waiting_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            choice_q  <= choice_d;
            timeout_q <= timeout_d;
        end
    end

    assign macro_states       = code_q;
    assign macro_states_valid = valid_q;
    assign seq_busy           = busy_q;
    assign flash_addr         = addr_q;
    assign uart_rx_cnt        = cnt_q;
    assign err_timeout        = timeout_q;

endmodule

// File: tb/tb_qspi_macro_sequencer.sv
// Directed self-checking bench for qspi_macro_sequencer; acts as the UART and flash slaves.
module tb_qspi_macro_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  macro_states;
    logic        macro_states_valid;
    logic        uart_done = 1'b0;
    logic [31:0] uart_rx_num = 32'd0;
    logic [15:0] uart_rx_cnt;
    logic        flash_done = 1'b0;
    logic [7:0]  flash_sr = 8'd0;
    logic [31:0] flash_addr;
    logic        err_timeout;
    logic        seq_busy;

    int total = 0;
    int bad   = 0;

    qspi_macro_sequencer #(
        .PAGE_BYTES (256),
        .SR_POLL_MAX(4),
        .WIP_BIT    (0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .macro_states      (macro_states),
        .macro_states_valid(macro_states_valid),
        .uart_done         (uart_done),
        .uart_rx_num       (uart_rx_num),
        .uart_rx_cnt       (uart_rx_cnt),
        .flash_done        (flash_done),
        .flash_sr          (flash_sr),
        .flash_addr        (flash_addr),
        .err_timeout       (err_timeout),
        .seq_busy          (seq_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next command strobe and checks code, busy and single-cycle strobe.
    task automatic wait_cmd(input logic [3:0] code, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!macro_states_valid && n < 200);
        chk({31'd0, macro_states_valid}, 32'd1, {tag, " valid"});
        chk({28'd0, macro_states}, {28'd0, code}, {tag, " code"});
        chk({31'd0, seq_busy}, 32'd1, {tag, " busy"});
        @(negedge clk);
        chk({31'd0, macro_states_valid}, 32'd0, {tag, " one strobe"});
        chk({28'd0, macro_states}, {28'd0, code}, {tag, " code held"});
    endtask

    task automatic uart_reply(input logic [31:0] num, input int dly, input string tag);
        repeat (dly) @(negedge clk);
        chk({31'd0, seq_busy}, 32'd1, {tag, " busy before done"});
        uart_done   = 1'b1;
        uart_rx_num = num;
        @(negedge clk);
        uart_done   = 1'b0;
        uart_rx_num = 32'd0;
        chk({31'd0, seq_busy}, 32'd0, {tag, " busy after done"});
    endtask

    task automatic flash_reply(input logic [7:0] sr, input int dly, input string tag);
        repeat (dly) @(negedge clk);
        chk({31'd0, seq_busy}, 32'd1, {tag, " busy before done"});
        flash_done = 1'b1;
        flash_sr   = sr;
        @(negedge clk);
        flash_done = 1'b0;
        flash_sr   = 8'd0;
        chk({31'd0, seq_busy}, 32'd0, {tag, " busy after done"});
    endtask

    task automatic menu_choice(input logic [3:0] choice, input string tag);
        wait_cmd(4'h1, {tag, " menu"});
        uart_reply(32'd0, 2, {tag, " menu"});
        wait_cmd(4'h5, {tag, " choice"});
        uart_reply({28'd0, choice}, 2, {tag, " choice"});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({28'd0, macro_states}, 32'd0, {tag, " macro_states"});
        chk({31'd0, macro_states_valid}, 32'd0, {tag, " valid"});
        chk({16'd0, uart_rx_cnt}, 32'd0, {tag, " uart_rx_cnt"});
        chk(flash_addr, 32'd0, {tag, " flash_addr"});
        chk({31'd0, err_timeout}, 32'd0, {tag, " err_timeout"});
        chk({31'd0, seq_busy}, 32'd0, {tag, " seq_busy"});
    endtask

    logic [15:0] page_cnt [3] = '{16'd256, 16'd256, 16'h50};
    logic [31:0] page_addr[3] = '{32'h1000, 32'h1100, 32'h1200};

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Startup menu with a 10-cycle UART response, choice 1 (read ID)
        wait_cmd(4'h1, "boot menu");
        uart_reply(32'd0, 10, "boot menu");
        wait_cmd(4'h5, "boot choice");
        // A stray flash done while waiting on the UART must be ignored.
        flash_done = 1'b1;
        @(negedge clk);
        flash_done = 1'b0;
        chk({31'd0, seq_busy}, 32'd1, "non-target done ignored");
        uart_reply(32'd1, 2, "boot choice");
        wait_cmd(4'hB, "rdid");
        chk(flash_addr, 32'd0, "rdid addr");
        flash_reply(8'h00, 4, "rdid");
        wait_cmd(4'h4, "rdid newline");
        uart_reply(32'd0, 1, "rdid newline");

        // Erase: address truncated to 4 kB, WIP set twice then clear
        menu_choice(4'd2, "erase");
        wait_cmd(4'h2, "erase addr q");
        uart_reply(32'd0, 1, "erase addr q");
        wait_cmd(4'h5, "erase addr rx");
        uart_reply(32'h0001_2345, 1, "erase addr rx");
        wait_cmd(4'hA, "erase cmd");
        chk(flash_addr, 32'h0001_2000, "erase aligned addr");
        flash_reply(8'h00, 3, "erase cmd");
        wait_cmd(4'hE, "erase poll1");
        flash_reply(8'h01, 1, "erase poll1");
        wait_cmd(4'hE, "erase poll2");
        flash_reply(8'h01, 1, "erase poll2");
        wait_cmd(4'hE, "erase poll3");
        flash_reply(8'h00, 1, "erase poll3");
        chk({31'd0, err_timeout}, 32'd0, "erase no timeout");
        wait_cmd(4'h4, "erase newline");
        uart_reply(32'd0, 1, "erase newline");

        // Program 0x250 bytes at 0x1000 as three pages
        menu_choice(4'd4, "prog");
        wait_cmd(4'h2, "prog addr q");
        uart_reply(32'd0, 1, "prog addr q");
        wait_cmd(4'h5, "prog addr rx");
        uart_reply(32'h0000_1000, 1, "prog addr rx");
        wait_cmd(4'h3, "prog len q");
        uart_reply(32'd0, 1, "prog len q");
        wait_cmd(4'h5, "prog len rx");
        uart_reply(32'h0000_0250, 1, "prog len rx");
        wait_cmd(4'h6, "prog file q");
        uart_reply(32'd0, 1, "prog file q");
        for (int p = 0; p < 3; p++) begin
            wait_cmd(4'h7, $sformatf("page%0d buf", p));
            chk({16'd0, uart_rx_cnt}, {16'd0, page_cnt[p]}, $sformatf("page%0d buf cnt", p));
            chk(flash_addr, page_addr[p], $sformatf("page%0d buf addr", p));
            uart_reply(32'd0, 2, $sformatf("page%0d buf", p));
            wait_cmd(4'hC, $sformatf("page%0d wr", p));
            chk({16'd0, uart_rx_cnt}, {16'd0, page_cnt[p]}, $sformatf("page%0d wr cnt", p));
            chk(flash_addr, page_addr[p], $sformatf("page%0d wr addr", p));
            flash_reply(8'h00, 2, $sformatf("page%0d wr", p));
            wait_cmd(4'hE, $sformatf("page%0d poll", p));
            flash_reply(8'h00, 1, $sformatf("page%0d poll", p));
        end
        wait_cmd(4'h4, "prog newline");
        chk(flash_addr, 32'h0000_1250, "prog final addr");
        uart_reply(32'd0, 1, "prog newline");

        // Program with zero length: no file prompt, straight to newline
        menu_choice(4'd4, "len0");
        wait_cmd(4'h2, "len0 addr q");
        uart_reply(32'd0, 1, "len0 addr q");
        wait_cmd(4'h5, "len0 addr rx");
        uart_reply(32'h0000_2000, 1, "len0 addr rx");
        wait_cmd(4'h3, "len0 len q");
        uart_reply(32'd0, 1, "len0 len q");
        wait_cmd(4'h5, "len0 len rx");
        uart_reply(32'd0, 1, "len0 len rx");
        wait_cmd(4'h4, "len0 newline");
        uart_reply(32'd0, 1, "len0 newline");

        // Unknown choice
        menu_choice(4'd7, "choice7");
        wait_cmd(4'h4, "choice7 newline");
        uart_reply(32'd0, 1, "choice7 newline");

        // Erase with WIP stuck: four polls then a one-cycle timeout
        menu_choice(4'd2, "tmo");
        wait_cmd(4'h2, "tmo addr q");
        uart_reply(32'd0, 1, "tmo addr q");
        wait_cmd(4'h5, "tmo addr rx");
        uart_reply(32'h00AB_CFFF, 1, "tmo addr rx");
        wait_cmd(4'hA, "tmo erase");
        chk(flash_addr, 32'h00AB_C000, "tmo aligned addr");
        flash_reply(8'h00, 1, "tmo erase");
        for (int k = 0; k < 4; k++) begin
            wait_cmd(4'hE, $sformatf("tmo poll%0d", k));
            chk({31'd0, err_timeout}, 32'd0, $sformatf("tmo poll%0d no err", k));
            flash_reply(8'hFF, 1, $sformatf("tmo poll%0d", k));
        end
        chk({31'd0, err_timeout}, 32'd1, "tmo err pulse");
        @(negedge clk);
        chk({31'd0, err_timeout}, 32'd0, "tmo err one cycle");
        chk({31'd0, macro_states_valid}, 32'd1, "tmo newline valid");
        chk({28'd0, macro_states}, 32'h4, "tmo newline code");
        uart_reply(32'd0, 1, "tmo newline");

        // Reset while waiting on flash_done
        menu_choice(4'd1, "rst");
        wait_cmd(4'hB, "rst rdid");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid reset");
        rst = 1'b0;
        wait_cmd(4'h1, "post reset menu");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
